aes_ctr_sequencer: RTL
======================

// Module: aes_ctr_sequencer
// PURPOSE
//  Stand-alone AES-CTR engine controller. Drives the AES core's word register bus to
//  load key/config, run INIT, then per input block write counter, pulse NEXT, poll,
//  read keystream and XOR with input data. Sits between a 128-bit data stream and the AES core.
// PARAMETERS
//  CTR_W          32    width of incrementing counter field (IV[CTR_W-1:0]), 1..128
//  TIMEOUT_CYCLES 1024  max status-poll cycles before error (only with AES_CTR_TIMEOUT_EN)
// PORTS
//  aclk        in   1    clock
//  aresetn     in   1    async active-low reset
//  start       in   1    1-cycle pulse; samples key/key_len/iv; ignored unless idle
//  key         in   256  key; key[255:224] -> reg 0x06 ... key[31:0] -> reg 0x0D
//  key_len     in   1    0=AES-128 (upper 128 bits used, lower words written 0), 1=AES-256
//  iv          in   128  initial counter block
//  busy        out  1    high from accepted start until abort/reset
//  s_valid/s_ready/s_data   in/out/in  1/1/128   plaintext stream
//  m_valid/m_ready/m_data   out/in/out 1/1/128   ciphertext stream
//  abort       in   1    returns to IDLE at the next safe point (see below)
//  err         out  1    1-cycle pulse on poll timeout
//  aes_cs/aes_we  out 1/1  register bus strobe / write enable
//  aes_addr    out  8    word address
//  aes_wdata   out  32   write data
//  aes_rdata   in   32   read data, valid the cycle after cs&~we
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, counter 0.
//  Core map (word addr): CTRL 0x00 (b0 init, b1 next), CONFIG 0x01 (b0 encdec, b1 keylen),
//   STATUS 0x02 (b0 ready, b1 valid), KEY 0x06-0x0D, BLOCK 0x0E-0x11, RESULT 0x12-0x15.
//   Word 0 of any 128/256-bit field is the MS word.
//  Bus: at most one access per cycle; each access is a 1-cycle cs pulse.
//  FSM:
//   IDLE   -> KEY on start (latch key, key_len, ctr<=iv, busy<=1)
//   KEY    8 writes 0x06..0x0D, one per cycle -> CFG
//   CFG    write 0x01 = {30'b0,key_len,1'b1} -> INIT1
//   INIT1  write CTRL=1 -> INIT0; INIT0 write CTRL=0 -> PINIT
//   PINIT  read STATUS; repeat until b0=1 -> WAIT
//   WAIT   s_ready=1; on s_valid latch s_data -> BLK
//   BLK    4 writes ctr words to 0x0E..0x11 -> NEXT1
//   NEXT1  CTRL=2 -> NEXT0; NEXT0 CTRL=0 -> PNEXT
//   PNEXT  read STATUS; repeat until b1=1 -> RES
//   RES    4 reads 0x12..0x15; m_data word i = rdata ^ data word i -> OUT
//   OUT    m_valid=1, m_data stable; on m_ready -> WAIT
//  Polls: read issued, rdata checked next cycle, reissued immediately if not set.
//  s_ready high only in WAIT; m_valid high only in OUT; AXI-style valid/ready rules.
//  Counter: after each RES completes, ctr[CTR_W-1:0] += 1 mod 2^CTR_W;
//   ctr[127:CTR_W] never changes (wrap does not carry).
//  Throughput: 1 block per (4+2+poll+4+1+handshake) cycles; no overlap.
//  abort: honoured in WAIT or OUT (or while polling) -> IDLE, busy<=0, data dropped;
//   never mid-write-burst. start while busy: ignored. Async reset mid-op: immediate IDLE.
//  Simultaneous start & abort in IDLE: start wins.
// CONFIGURATION
//  AES_CTR_TIMEOUT_EN defined: per-poll counter; if PINIT/PNEXT exceeds TIMEOUT_CYCLES
//   read cycles -> err pulse 1 cycle, IDLE, busy<=0.
//  Not defined: polls wait forever; err tied 0.
// TESTING
//  1 Reset: aresetn=0 mid-BLK -> all outputs 0, busy 0, no cs next cycle.
//  2 SP800-38A F.5.1: key 2b7e151628aed2a6abf7158809cf4f3c, iv f0f1..feff,
//    pt 6bc1bee22e409f96e93d7e117393172a -> m_data 874d6191b620e3261bef6864990db6ce;
//    bus log = 8 key wr, CONFIG=0x1, CTRL 1,0 as specified.
//  3 Second block ae2d8a571e03ac9c9eb76fac45af8e51 -> 9806f66b7970fdff8617187bb9fffdff;
//    BLOCK word 3 written = fcfdff00.
//  4 CTR_W=32, iv low word ffffffff, 2 blocks -> 2nd BLOCK writes low word 00000000,
//    word 2 unchanged.
//  5 m_ready held 0 for 20 cycles -> m_data stable, s_ready 0, no bus traffic.
//  6 AES_CTR_TIMEOUT_EN, TIMEOUT_CYCLES=16, STATUS stuck 0 -> err pulse after 16 polls,
//    busy 0; abort in WAIT -> IDLE next cycle.

Source files
------------

// File: rtl/aes_ctr_sequencer_if.sv
// Stream and AES-core register bus bundle for aes_ctr_sequencer.
// master = sequencer side, slave = stream source/sink plus AES core.
interface aes_ctr_sequencer_if;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] s_data;
  logic         m_valid;
  logic         m_ready;
  logic [127:0] m_data;
  logic         aes_cs;
  logic         aes_we;
  logic [7:0]   aes_addr;
  logic [31:0]  aes_wdata;
  logic [31:0]  aes_rdata;

  modport master (
    input  s_valid, s_data, m_ready, aes_rdata,
    output s_ready, m_valid, m_data, aes_cs, aes_we, aes_addr, aes_wdata
  );

  modport slave (
    output s_valid, s_data, m_ready, aes_rdata,
    input  s_ready, m_valid, m_data, aes_cs, aes_we, aes_addr, aes_wdata
  );
endinterface

// File: rtl/aes_ctr_sequencer.sv
// AES-CTR controller: programs the AES core word bus, XORs keystream onto a 128-bit stream. Option macro: AES_CTR_TIMEOUT_EN.
// Latency: 11-cycle key/init setup plus poll, then 4+2+poll+5 cycles per block; one block in flight.
// Backpressure: s_ready only while waiting for a block; m_data held stable until m_ready.
module aes_ctr_sequencer #(
  parameter int CTR_W          = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                start,
  input  logic [255:0]        key,
  input  logic                key_len,
  input  logic [127:0]        iv,
  output logic                busy,
  input  logic                abort,
  output logic                err,
  aes_ctr_sequencer_if.master bus
);

  if (CTR_W < 1 || CTR_W > 128 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("aes_ctr_sequencer: CTR_W must be 1..128 and TIMEOUT_CYCLES >= 1");
  end

  // Shift by 128 yields 0, so the mask becomes all ones for CTR_W = 128.
  localparam logic [127:0] CTR_MASK = (128'd1 << CTR_W) - 128'd1;

  typedef enum logic [3:0] {
    S_IDLE, S_KEY, S_CFG, S_INIT1, S_INIT0, S_PINIT, S_WAIT,
    S_BLK, S_NEXT1, S_NEXT0, S_PNEXT, S_RES, S_OUT
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic             pend_q, pend_d;
  logic [7:0][31:0] key_q;
  logic             klen_q;
  logic [3:0][31:0] ctr_q;
  logic [3:0][31:0] dat_q;
  logic [3:0][31:0] mdat_q;
  logic             busy_q;

  logic             cs, we;
  logic [7:0]       addr;
  logic [31:0]      wdata;
  logic             ld_key, ld_dat, cap_res, ctr_inc, busy_clr;
  logic             stat_bit;
  logic [2:0]       key_sel, cap_tmp;
  logic [1:0]       ctr_sel, cap_sel;

  assign key_sel  = 3'd7 - idx_q;
  assign ctr_sel  = 2'd3 - idx_q[1:0];
  // RES captures the word read on the previous cycle, i.e. word idx-1.
  assign cap_tmp  = 3'd4 - idx_q;
  assign cap_sel  = cap_tmp[1:0];
  assign stat_bit = (state_q == S_PINIT) ? bus.aes_rdata[0] : bus.aes_rdata[1];

`ifdef AES_CTR_TIMEOUT_EN
  logic [31:0] poll_cnt_q;
  logic        err_q, tmo_hit, polling;
  assign polling = (state_q == S_PINIT) || (state_q == S_PNEXT);
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pend_d   = pend_q;
    cs       = 1'b0;
    we       = 1'b0;
    addr     = 8'h00;
    wdata    = 32'h0;
    ld_key   = 1'b0;
    ld_dat   = 1'b0;
    cap_res  = 1'b0;
    ctr_inc  = 1'b0;
    busy_clr = 1'b0;
`ifdef AES_CTR_TIMEOUT_EN
    tmo_hit  = 1'b0;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        ld_key  = 1'b1;
        idx_d   = '0;
        state_d = S_KEY;
      end
      S_KEY: begin
        cs = 1'b1; we = 1'b1;
        addr  = 8'h06 + {5'b0, idx_q};
        wdata = key_q[key_sel];
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = S_CFG;
      end
      S_CFG: begin
        cs = 1'b1; we = 1'b1; addr = 8'h01;
        wdata   = {30'b0, klen_q, 1'b1};
        state_d = S_INIT1;
      end
      S_INIT1: begin
        cs = 1'b1; we = 1'b1; wdata = 32'h1;
        state_d = S_INIT0;
      end
      S_INIT0: begin
        cs = 1'b1; we = 1'b1;
        pend_d  = 1'b0;
        state_d = S_PINIT;
      end
      S_PINIT, S_PNEXT: begin
        if (abort) begin
          busy_clr = 1'b1;
          state_d  = S_IDLE;
        end else if (pend_q && stat_bit) begin
          pend_d  = 1'b0;
          idx_d   = '0;
          state_d = (state_q == S_PINIT) ? S_WAIT : S_RES;
`ifdef AES_CTR_TIMEOUT_EN
        end else if (pend_q && poll_cnt_q == 32'(TIMEOUT_CYCLES)) begin
          tmo_hit  = 1'b1;
          busy_clr = 1'b1;
          state_d  = S_IDLE;
`endif
        end else begin
          cs = 1'b1; addr = 8'h02;
          pend_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (abort) begin
          busy_clr = 1'b1;
          state_d  = S_IDLE;
        end else if (bus.s_valid) begin
          ld_dat  = 1'b1;
          idx_d   = '0;
          state_d = S_BLK;
        end
      end
      S_BLK: begin
        cs = 1'b1; we = 1'b1;
        addr  = 8'h0E + {6'b0, idx_q[1:0]};
        wdata = ctr_q[ctr_sel];
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd3) state_d = S_NEXT1;
      end
      S_NEXT1: begin
        cs = 1'b1; we = 1'b1; wdata = 32'h2;
        state_d = S_NEXT0;
      end
      S_NEXT0: begin
        cs = 1'b1; we = 1'b1;
        pend_d  = 1'b0;
        state_d = S_PNEXT;
      end
      S_RES: begin
        if (idx_q != 3'd4) begin
          cs = 1'b1;
          addr = 8'h12 + {6'b0, idx_q[1:0]};
        end
        if (idx_q != 3'd0) cap_res = 1'b1;
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd4) begin
          ctr_inc = 1'b1;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (abort) begin
          busy_clr = 1'b1;
          state_d  = S_IDLE;
        end else if (bus.m_ready) begin
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      key_q  <= '0;
      klen_q <= 1'b0;
      ctr_q  <= '0;
      dat_q  <= '0;
      mdat_q <= '0;
      busy_q <= 1'b0;
    end else begin
      if (ld_key) begin
        key_q  <= key_len ? key : {key[255:128], 128'b0};
        klen_q <= key_len;
        ctr_q  <= iv;
        busy_q <= 1'b1;
      end
      if (busy_clr) busy_q <= 1'b0;
      if (ld_dat)   dat_q  <= bus.s_data;
      if (cap_res)  mdat_q[cap_sel] <= bus.aes_rdata ^ dat_q[cap_sel];
      if (ctr_inc)  ctr_q <= (ctr_q & ~CTR_MASK) | ((ctr_q + 128'd1) & CTR_MASK);
    end
  end

`ifdef AES_CTR_TIMEOUT_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      poll_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= tmo_hit;
      if (!polling)  poll_cnt_q <= '0;
      else if (cs)   poll_cnt_q <= poll_cnt_q + 32'd1;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign bus.aes_cs    = cs;
  assign bus.aes_we    = we;
  assign bus.aes_addr  = addr;
  assign bus.aes_wdata = wdata;
  assign bus.s_ready   = (state_q == S_WAIT);
  assign bus.m_valid   = (state_q == S_OUT);
  assign bus.m_data    = mdat_q;
  assign busy          = busy_q;

endmodule
